// File: rtl/bcd_pkg.sv
// Shared types and constants for the binary-to-BCD display preparation block.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_e;

    localparam logic [3:0] BCD_NINE      = 4'd9;
    localparam logic [3:0] DABBLE_THRESH = 4'd5;
    localparam logic [3:0] DABBLE_ADD    = 4'd3;

    localparam int DEF_WIDTH = 20;
    localparam int CNT_W     = $clog2(DEF_WIDTH + 1);

    // Counter width able to hold the value w itself.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// Combinational double-dabble correction: every BCD digit >= 5 gets +3
// so that the following left shift carries correctly into the next digit.
module bcd_dabble_step
    import bcd_pkg::*;
#(
    parameter int INT_DIGITS = 7
) (
    input  logic [4*INT_DIGITS-1:0] acc_i,
    output logic [4*INT_DIGITS-1:0] acc_o
);

    always_comb begin
        acc_o = acc_i;
        for (int i = 0; i < INT_DIGITS; i++) begin
            if (acc_i[4*i +: 4] >= DABBLE_THRESH) begin
                acc_o[4*i +: 4] = acc_i[4*i +: 4] + DABBLE_ADD;
            end
        end
    end

endmodule

// File: rtl/bin2bcd_display_prep.sv
// Iterative binary-to-BCD converter feeding the seven-segment display stage.
// One bit per clock, WIDTH cycles per value; result held in DONE until consumed.
module bin2bcd_display_prep
    import bcd_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int DIGITS     = 6,
    parameter int INT_DIGITS = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      in_value,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]     blank_out,
    output logic                  overflow,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int CW = cnt_width(WIDTH);
    localparam int AW = 4 * INT_DIGITS;
    localparam int BW = 4 * DIGITS;
    localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  sh_q, sh_d;
    logic [AW-1:0]     acc_q, acc_d;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic [DIGITS-1:0] blank_q, blank_d;
    logic              ovf_q, ovf_d;

    logic [AW-1:0]       acc_corr;
    logic [AW+WIDTH-1:0] cat_shift;
    logic [AW-1:0]       acc_shift;
    logic [WIDTH-1:0]    sh_shift;
    logic [BW-1:0]       fmt_bcd;
    logic [DIGITS-1:0]   fmt_blank;
    logic                fmt_ovf;
    logic                zero_run;
    logic                accept;

    bcd_dabble_step #(
        .INT_DIGITS (INT_DIGITS)
    ) u_step (
        .acc_i (acc_q),
        .acc_o (acc_corr)
    );

    always_comb begin
        cat_shift = {acc_corr, sh_q} << 1;
        acc_shift = cat_shift[AW+WIDTH-1:WIDTH];
        sh_shift  = cat_shift[WIDTH-1:0];
    end

    // Formatting of the accumulator as it will stand after the final shift.
    always_comb begin
        fmt_ovf   = |acc_shift[AW-1:BW];
        fmt_bcd   = fmt_ovf ? {DIGITS{BCD_NINE}} : acc_shift[BW-1:0];
        fmt_blank = '0;
        zero_run  = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run     = zero_run & (fmt_bcd[4*i +: 4] == 4'd0);
            fmt_blank[i] = zero_run & ~fmt_ovf;
        end
    end

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign bcd_out   = bcd_q;
    assign blank_out = blank_q;
    assign overflow  = ovf_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        acc_d   = acc_q;
        bcd_d   = bcd_q;
        blank_d = blank_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    sh_d    = in_value;
                    acc_d   = '0;
                    cnt_d   = CW'(WIDTH);
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                acc_d = acc_shift;
                sh_d  = sh_shift;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    bcd_d   = fmt_bcd;
                    blank_d = fmt_blank;
                    ovf_d   = fmt_ovf;
                    state_d = DONE;
                end
            end
            DONE: begin
                // Consume and re-accept on the same edge keeps the pipe full.
                if (accept) begin
                    sh_d    = in_value;
                    acc_d   = '0;
                    cnt_d   = CW'(WIDTH);
                    state_d = CONVERT;
                end else if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            acc_q   <= '0;
            bcd_q   <= '0;
            blank_q <= BLANK_RST;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            acc_q   <= acc_d;
            bcd_q   <= bcd_d;
            blank_q <= blank_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_bin2bcd_display_prep.sv
// Directed bench for bin2bcd_display_prep: latency, formatting, backpressure, reset.
module tb_bin2bcd_display_prep;

    logic        clk;
    logic        rst;
    logic [19:0] in_value;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] bcd_out;
    logic [5:0]  blank_out;
    logic        overflow;
    logic        out_valid;
    logic        out_ready;

    int checks = 0;
    int errors = 0;

    bin2bcd_display_prep dut (
        .clk       (clk),
        .rst       (rst),
        .in_value  (in_value),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bcd_out   (bcd_out),
        .blank_out (blank_out),
        .overflow  (overflow),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic accept(input logic [19:0] v);
        @(negedge clk);
        in_value = v;
        in_valid = 1'b1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_ready value=%0d got %b want 1", v, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Counts edges after the accepting edge until out_valid rises.
    task automatic wait_result(input string name, input int want_n);
        int n;
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (out_valid === 1'b1) break;
        end
        checks++;
        if (out_valid !== 1'b1 || n != want_n) begin
            errors++;
            $display("FAIL %s_latency got %0d cycles (valid=%b) want %0d", name, n, out_valid, want_n);
        end
    endtask

    task automatic check_out(input string name, input logic [23:0] bcd,
                             input logic [5:0] blank, input logic ovf);
        checks++;
        if (bcd_out !== bcd || blank_out !== blank || overflow !== ovf) begin
            errors++;
            $display("FAIL %s got bcd=%h blank=%b ovf=%b want bcd=%h blank=%b ovf=%b",
                     name, bcd_out, blank_out, overflow, bcd, blank, ovf);
        end
    endtask

    task automatic consume(input string name);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_consume got valid=%b ready=%b want valid=0 ready=1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs got ready=%b valid=%b want ready=1 valid=0", in_ready, out_valid);
        end
        check_out("reset_out", 24'h000000, 6'b111110, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_zero();
        accept(20'd0);
        wait_result("zero", 20);
        check_out("zero_out", 24'h000000, 6'b111110, 1'b0);
        consume("zero");
        check_out("zero_keep", 24'h000000, 6'b111110, 1'b0);
    endtask

    task automatic test_ignore_busy();
        accept(20'd123456);
        // A competing value during CONVERT must be ignored.
        in_value = 20'd77;
        in_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL busy_ready got %b want 0", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_result("v123456", 19);
        check_out("v123456_out", 24'h123456, 6'b000000, 1'b0);
        consume("v123456");
    endtask

    task automatic test_back_to_back();
        accept(20'd42);
        wait_result("v42", 20);
        check_out("v42_out", 24'h000042, 6'b111100, 1'b0);
        consume("v42");
        accept(20'd999999);
        wait_result("v999999", 20);
        check_out("v999999_out", 24'h999999, 6'b000000, 1'b0);
        consume("v999999");
    endtask

    task automatic test_max();
        accept(20'd1048575);
        wait_result("max", 20);
        check_out("max_out", 24'h999999, 6'b000000, 1'b1);
        consume("max");
    endtask

    task automatic test_backpressure();
        accept(20'd8000);
        wait_result("bp", 20);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cycle=%0d got valid=%b ready=%b want valid=1 ready=0", i, out_valid, in_ready);
            end
            check_out("bp_hold_out", 24'h008000, 6'b110000, 1'b0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_value  = 20'd7;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_reaccept_ready got %b want 1", in_ready);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_valid_clear got %b want 0", out_valid);
        end
        check_out("bp_old_kept", 24'h008000, 6'b110000, 1'b0);
        wait_result("bp_v7", 20);
        check_out("bp_v7_out", 24'h000007, 6'b111110, 1'b0);
        consume("bp_v7");
    endtask

    task automatic test_reset_midconvert();
        accept(20'd555555);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_hs got ready=%b valid=%b want ready=1 valid=0", in_ready, out_valid);
        end
        check_out("midrst_out", 24'h000000, 6'b111110, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_discard got valid=%b want 0", out_valid);
        end
        accept(20'd31);
        wait_result("v31", 20);
        check_out("v31_out", 24'h000031, 6'b111100, 1'b0);
        consume("v31");
    endtask

    initial begin
        rst       = 1'b1;
        in_value  = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_zero();
        test_ignore_busy();
        test_back_to_back();
        test_max();
        test_backpressure();
        test_reset_midconvert();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
